hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard and stall/flush sequencer for the 5-stage core. Drives the
//  stall/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Handles load-use bubbles, taken-branch/jump redirects and bus wait states.
//  A taken redirect that arrives during a bus wait is remembered and replayed
//  when the wait ends. Saturating stall/flush event counters for perf debug.
// PARAMETERS
//  CNT_W  32  width of stall_cnt / flush_cnt
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  id_rs1_addr    in   5      rs1 of instr in ID
//  id_rs2_addr    in   5      rs2 of instr in ID
//  id_rs1_used    in   1      ID instr reads rs1
//  id_rs2_used    in   1      ID instr reads rs2
//  ex_rd_addr     in   5      rd of instr in EX (ID/EX RdAddr)
//  ex_mem_read    in   1      EX instr is a load
//  ex_branch_taken in  1      EX resolved taken branch/jump (may pulse 1 cycle)
//  im_wait        in   1      instruction bus not ready
//  dm_wait        in   1      data bus not ready
//  cnt_clr        in   1      synchronous clear of both counters
//  pc_stall       out  1      hold PC
//  IF_stall       out  1      hold IF/ID
//  IF_flush       out  1      zero IF/ID
//  ID_stall       out  1      hold ID/EX
//  ID_flush       out  1      zero ID/EX (bubble)
//  EX_stall       out  1      hold EX/MEM
//  MEM_stall      out  1      hold MEM/WB
//  stall_cnt      out  CNT_W  cycles with pc_stall=1, saturating
//  flush_cnt      out  CNT_W  cycles with ID_flush=1, saturating
// BEHAVIOUR
//  - Reset: state=RUN, pend=0, counters=0; all control outputs 0 while rst=1.
//  - wait = im_wait|dm_wait. lu = ex_mem_read & ex_rd_addr!=0 &
//    ((id_rs1_used & rs1==rd)|(id_rs2_used & rs2==rd)).
//  - Controls are combinational from state + inputs (same-cycle effect).
//  - RUN: wait=1 -> all five stalls=1, flushes=0; pend<=ex_branch_taken;
//    next WAIT. Else ex_branch_taken -> IF_flush=ID_flush=1, no stalls.
//    Else lu -> pc_stall=IF_stall=ID_flush=1 (1-cycle bubble). Else all 0.
//    Priority: wait > branch > load-use.
//  - WAIT: while wait=1 all stalls=1, flushes=0; pend<=pend|ex_branch_taken.
//    When wait=0: if pend|ex_branch_taken -> next FLUSH, outputs all 0 this
//    cycle; else behave as RUN this cycle, next RUN.
//  - FLUSH (1 cycle): IF_flush=ID_flush=1, pc unstalled (datapath holds
//    redirect target); pend<=0; if wait=1 stalls override, flushes held off,
//    stay FLUSH. Next RUN.
//  - Simultaneous im_wait and dm_wait: single WAIT; exit only when both 0.
//  - Counters: +1 per cycle of condition, hold at all-ones; cnt_clr wins
//    over increment. rst mid-operation drops pend and returns to RUN.
// TESTING
//  1 rst pulse mid-WAIT -> state RUN, pend=0, counters 0, controls 0.
//  2 lw x5 in EX, ID add reads x5 (rs1_used) -> 1 cycle pc_stall=IF_stall=
//    ID_flush=1, next cycle ex_mem_read=0 -> controls 0; rd=x0 -> no bubble.
//  3 ex_branch_taken + lu same cycle -> IF_flush=ID_flush=1, pc_stall=0.
//  4 dm_wait 3 cycles, ex_branch_taken pulse in cycle 1 -> 3 stall cycles,
//    1 idle, then 1 cycle IF_flush=ID_flush=1; stall_cnt=3, flush_cnt=1.
//  5 im_wait 0..4, dm_wait 2..6 overlap -> stalls continuous 7 cycles.
//  6 CNT_W=4, 20 stall cycles -> stall_cnt=15; cnt_clr with stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// redirect flushes, bus wait holds with deferred redirect replay.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             im_wait,
  input  logic             dm_wait,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             IF_stall,
  output logic             IF_flush,
  output logic             ID_stall,
  output logic             ID_flush,
  output logic             EX_stall,
  output logic             MEM_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_FLUSH
  } state_e;

  state_e state_q, state_d;
  logic   pend_q, pend_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic bus_wait;
  logic lu;
  logic rs1_hit;
  logic rs2_hit;
  logic stall_all;
  logic flush_br;
  logic bubble;

  assign bus_wait = im_wait | dm_wait;
  assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign lu       = ex_mem_read & (ex_rd_addr != 5'd0)
                  & (rs1_hit | rs2_hit);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    stall_all = 1'b0;
    flush_br  = 1'b0;
    bubble    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (bus_wait) begin
          stall_all = 1'b1;
          pend_d    = ex_branch_taken;
          state_d   = S_WAIT;
        end else if (ex_branch_taken) begin
          flush_br = 1'b1;
        end else if (lu) begin
          bubble = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus_wait) begin
          stall_all = 1'b1;
          pend_d    = pend_q | ex_branch_taken;
        end else if (pend_q | ex_branch_taken) begin
          // idle cycle lets the redirect target reach the PC first
          state_d = S_FLUSH;
        end else begin
          bubble  = lu;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        pend_d = 1'b0;
        if (bus_wait) begin
          stall_all = 1'b1;
        end else begin
          flush_br = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: begin
        pend_d  = 1'b0;
        state_d = S_RUN;
      end
    endcase
  end

  assign pc_stall  = ~rst & (stall_all | bubble);
  assign IF_stall  = ~rst & (stall_all | bubble);
  assign IF_flush  = ~rst & flush_br;
  assign ID_stall  = ~rst & stall_all;
  assign ID_flush  = ~rst & (flush_br | bubble);
  assign EX_stall  = ~rst & stall_all;
  assign MEM_stall = ~rst & stall_all;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (pc_stall && !(&stall_cnt_q))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ID_flush && !(&flush_cnt_q))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control vectors
// and counter values, default and narrow counter instances.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd_addr;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       im_wait;
  logic       dm_wait;
  logic       cnt_clr;

  logic        pc_stall, IF_stall, IF_flush;
  logic        ID_stall, ID_flush, EX_stall, MEM_stall;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_stall4, IF_stall4, IF_flush4;
  logic        ID_stall4, ID_flush4, EX_stall4, MEM_stall4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int n_chk;
  int n_err;

  // {pc, IF_s, IF_f, ID_s, ID_f, EX_s, MEM_s}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] STL  = 7'b1101011;
  localparam logic [6:0] BRF  = 7'b0010100;
  localparam logic [6:0] LUB  = 7'b1100100;

  logic [6:0] ctl;
  logic [6:0] ctl4;
  assign ctl  = {pc_stall, IF_stall, IF_flush, ID_stall,
                 ID_flush, EX_stall, MEM_stall};
  assign ctl4 = {pc_stall4, IF_stall4, IF_flush4, ID_stall4,
                 ID_flush4, EX_stall4, MEM_stall4};

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .im_wait(im_wait), .dm_wait(dm_wait), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .IF_stall(IF_stall), .IF_flush(IF_flush),
    .ID_stall(ID_stall), .ID_flush(ID_flush),
    .EX_stall(EX_stall), .MEM_stall(MEM_stall),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .im_wait(im_wait), .dm_wait(dm_wait), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall4), .IF_stall(IF_stall4), .IF_flush(IF_flush4),
    .ID_stall(ID_stall4), .ID_flush(ID_flush4),
    .EX_stall(EX_stall4), .MEM_stall(MEM_stall4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr     = 5'd0;
    id_rs2_addr     = 5'd0;
    id_rs1_used     = 1'b0;
    id_rs2_used     = 1'b0;
    ex_rd_addr      = 5'd0;
    ex_mem_read     = 1'b0;
    ex_branch_taken = 1'b0;
    im_wait         = 1'b0;
    dm_wait         = 1'b0;
    cnt_clr         = 1'b0;
  endtask

  task automatic set_lu(input logic on);
    ex_mem_read = on;
    ex_rd_addr  = 5'd5;
    id_rs1_addr = 5'd5;
    id_rs1_used = on;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    #1;
    check("rst_ctl", {25'd0, ctl}, {25'd0, NONE});
    check("rst_scnt", stall_cnt, 32'd0);
    rst = 1'b0;
    step();

    // 1: reset while in WAIT holding a pending redirect
    dm_wait = 1'b1;
    ex_branch_taken = 1'b1;
    #1 check("t1_enter", {25'd0, ctl}, {25'd0, STL});
    step();
    ex_branch_taken = 1'b0;
    #1 check("t1_wait", {25'd0, ctl}, {25'd0, STL});
    #1 rst = 1'b1;
    #1 check("t1_rst_ctl", {25'd0, ctl}, {25'd0, NONE});
    check("t1_rst_scnt", stall_cnt, 32'd0);
    check("t1_rst_fcnt", flush_cnt, 32'd0);
    step();
    rst = 1'b0;
    dm_wait = 1'b0;
    #1 check("t1_run", {25'd0, ctl}, {25'd0, NONE});
    step();
    #1 check("t1_nopend", {25'd0, ctl}, {25'd0, NONE});
    step();

    // 2: load-use bubble and its boundaries
    set_lu(1'b1);
    #1 check("t2_lu", {25'd0, ctl}, {25'd0, LUB});
    step();
    ex_mem_read = 1'b0;
    #1 check("t2_after", {25'd0, ctl}, {25'd0, NONE});
    ex_mem_read = 1'b1;
    ex_rd_addr  = 5'd0;
    id_rs1_addr = 5'd0;
    #1 check("t2_x0", {25'd0, ctl}, {25'd0, NONE});
    idle();
    ex_mem_read = 1'b1;
    ex_rd_addr  = 5'd7;
    id_rs2_addr = 5'd7;
    id_rs2_used = 1'b1;
    #1 check("t2_rs2", {25'd0, ctl}, {25'd0, LUB});
    id_rs2_used = 1'b0;
    #1 check("t2_unused", {25'd0, ctl}, {25'd0, NONE});
    step();
    idle();

    // 3: redirect outranks load-use
    set_lu(1'b1);
    ex_branch_taken = 1'b1;
    #1 check("t3_br_lu", {25'd0, ctl}, {25'd0, BRF});
    step();
    idle();

    // 4: redirect captured during a 3-cycle data wait
    clr_cnt();
    dm_wait = 1'b1;
    ex_branch_taken = 1'b1;
    #1 check("t4_c0", {25'd0, ctl}, {25'd0, STL});
    step();
    ex_branch_taken = 1'b0;
    #1 check("t4_c1", {25'd0, ctl}, {25'd0, STL});
    step();
    #1 check("t4_c2", {25'd0, ctl}, {25'd0, STL});
    step();
    dm_wait = 1'b0;
    #1 check("t4_idle", {25'd0, ctl}, {25'd0, NONE});
    step();
    #1 check("t4_flush", {25'd0, ctl}, {25'd0, BRF});
    step();
    #1 check("t4_done", {25'd0, ctl}, {25'd0, NONE});
    check("t4_scnt", stall_cnt, 32'd3);
    check("t4_fcnt", flush_cnt, 32'd1);

    // redirect arriving on the cycle the wait ends
    im_wait = 1'b1;
    #1 check("e1_c0", {25'd0, ctl}, {25'd0, STL});
    step();
    im_wait = 1'b0;
    ex_branch_taken = 1'b1;
    #1 check("e1_exit", {25'd0, ctl}, {25'd0, NONE});
    step();
    ex_branch_taken = 1'b0;
    #1 check("e1_flush", {25'd0, ctl}, {25'd0, BRF});
    step();

    // wait reasserted during the replay flush cycle
    dm_wait = 1'b1;
    ex_branch_taken = 1'b1;
    #1 check("e2_c0", {25'd0, ctl}, {25'd0, STL});
    step();
    dm_wait = 1'b0;
    ex_branch_taken = 1'b0;
    #1 check("e2_exit", {25'd0, ctl}, {25'd0, NONE});
    step();
    im_wait = 1'b1;
    #1 check("e2_fl_wait", {25'd0, ctl}, {25'd0, STL});
    step();
    im_wait = 1'b0;
    #1 check("e2_fl_go", {25'd0, ctl}, {25'd0, BRF});
    step();
    #1 check("e2_run", {25'd0, ctl}, {25'd0, NONE});

    // wait ends without redirect while a load-use is present
    dm_wait = 1'b1;
    step();
    dm_wait = 1'b0;
    set_lu(1'b1);
    #1 check("e3_lu", {25'd0, ctl}, {25'd0, LUB});
    step();
    idle();

    // 5: overlapping instruction and data waits
    clr_cnt();
    for (int i = 0; i < 8; i++) begin
      im_wait = (i <= 4);
      dm_wait = (i >= 2 && i <= 6);
      #1 check($sformatf("t5_c%0d", i), {25'd0, ctl},
               {25'd0, (i <= 6) ? STL : NONE});
      step();
    end
    idle();
    check("t5_scnt", stall_cnt, 32'd7);
    check("t5_scnt4", {28'd0, stall_cnt4}, 32'd7);

    // 6: narrow counter saturation, clear beats increment
    dm_wait = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("t6_sat4", {28'd0, stall_cnt4}, 32'd15);
    check("t6_cnt32", stall_cnt, 32'd27);
    check("t6_ctl4", {25'd0, ctl4}, {25'd0, STL});
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t6_clr4", {28'd0, stall_cnt4}, 32'd0);
    check("t6_clr32", stall_cnt, 32'd0);
    step();
    check("t6_inc", {28'd0, stall_cnt4}, 32'd1);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
